// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port out of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  in_byte, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_byte, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream program loader writing big-endian words into instruction memory
module imem_loader #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         vec_sel,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);
    localparam int SUM_W = ((ADDR_W > 16) ? ADDR_W : 16) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cnt_hi;
    logic [15:0]        r_n;
    logic [15:0]        r_wcnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_hi;
    logic [7:0]         r_csum;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_done;
    logic               r_err;

    logic               w_ready;
    logic               w_busy;
    logic               w_accept;
    logic [15:0]        w_n;
    logic [SUM_W-1:0]   w_end;
    logic [SUM_W-1:0]   w_limit;
    logic               w_range_err;
    logic               w_last;
    logic               w_timeout;
    logic [ADDR_W-1:0]  w_base;

    assign w_accept    = bus.in_valid & w_ready;
    assign w_n         = {r_cnt_hi, bus.in_byte};
    assign w_base      = vec_sel ? '0 : ADDR_W'(BASE_ADDR);
    // r_addr still holds the base while the count is being completed
    assign w_end       = SUM_W'(r_addr) + SUM_W'(w_n);
    assign w_limit     = SUM_W'(1) << ADDR_W;
    assign w_range_err = (w_end > w_limit);
    assign w_last      = ((r_wcnt + 16'd1) == r_n);
    assign w_timeout   = w_ready & ~bus.in_valid & (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CNT_HI;
            S_CNT_HI: if (w_accept) w_next = S_CNT_LO;
            S_CNT_LO: begin
                if (w_accept) begin
                    if (w_range_err)     w_next = S_ERR;
                    else if (w_n == '0)  w_next = S_CHK;
                    else                 w_next = S_DAT_HI;
                end
            end
            S_DAT_HI: if (w_accept) w_next = S_DAT_LO;
            S_DAT_LO: if (w_accept) w_next = w_last ? S_CHK : S_DAT_HI;
            S_CHK:    if (w_accept) w_next = (bus.in_byte == r_csum) ? S_DONE : S_ERR;
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHK: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            S_DONE, S_ERR: w_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_hi    <= '0;
            r_n         <= '0;
            r_wcnt      <= '0;
            r_addr      <= '0;
            r_hi        <= '0;
            r_csum      <= '0;
            r_tmo       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (r_state == S_IDLE || w_accept) begin
                r_tmo <= '0;
            end else if (w_ready) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                        r_addr <= w_base;
                        r_wcnt <= '0;
                        r_csum <= '0;
                    end
                end
                S_CNT_HI: if (w_accept) r_cnt_hi <= bus.in_byte;
                S_CNT_LO: if (w_accept) r_n <= w_n;
                S_DAT_HI: begin
                    if (w_accept) begin
                        r_hi   <= bus.in_byte;
                        r_csum <= r_csum ^ bus.in_byte;
                    end
                end
                S_DAT_LO: begin
                    // write is registered so the next byte can be taken without a stall
                    if (w_accept) begin
                        r_csum      <= r_csum ^ bus.in_byte;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= DATA_W'({r_hi, bus.in_byte});
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_wcnt      <= r_wcnt + 16'd1;
                    end
                end
                S_DONE: r_done <= 1'b1;
                S_ERR:  r_err  <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign busy          = w_busy;
    assign cpu_hold      = w_busy;
    assign done          = r_done;
    assign err           = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic vec_sel = 1'b0;
    logic busy, cpu_hold, done, err;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(16)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(16), .BASE_ADDR(32), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .vec_sel  (vec_sel),
        .bus      (bus),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic v);
        @(negedge clk);
        start   = 1'b1;
        vec_sel = v;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send_byte: in_ready stayed %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, cpu_hold, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b we=%b addr=%h data=%h busy=%b hold=%b done=%b err=%b, required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, cpu_hold, done, err);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        wa.delete(); wd.delete();
        pulse_start(1'b0);
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: busy=%b hold=%b, required 1 1", busy, cpu_hold);
        end
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        send_byte(8'h40, 0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_hold: busy=%b hold=%b, required 1 1", busy, cpu_hold);
        end
        @(negedge clk);
        checks++;
        if ({busy, cpu_hold, done, err} !== 4'b0010) begin
            errors++;
            $display("FAIL basic_status: busy=%b hold=%b done=%b err=%b, required 0 0 1 0", busy, cpu_hold, done, err);
        end
        checks++;
        if (wa.size() != 2 || wa[0] !== 16'd32 || wd[0] !== 16'h1234 || wa[1] !== 16'd33 || wd[1] !== 16'hABCD) begin
            errors++;
            $display("FAIL basic_writes: count=%0d first=(%0d,%h) second=(%0d,%h), required 2 (32,1234) (33,abcd)",
                     wa.size(), (wa.size() > 0) ? wa[0] : 16'hx, (wd.size() > 0) ? wd[0] : 16'hx,
                     (wa.size() > 1) ? wa[1] : 16'hx, (wd.size() > 1) ? wd[1] : 16'hx);
        end
    endtask

    task automatic test_vector_stall;
        wa.delete(); wd.delete();
        pulse_start(1'b1);
        send_byte(8'h00, 3); send_byte(8'h01, 3);
        send_byte(8'h01, 3); send_byte(8'h00, 3);
        send_byte(8'h01, 3);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b010) begin
            errors++;
            $display("FAIL vector_status: busy=%b done=%b err=%b, required 0 1 0", busy, done, err);
        end
        checks++;
        if (wa.size() != 1 || wa[0] !== 16'd0 || wd[0] !== 16'h0100) begin
            errors++;
            $display("FAIL vector_write: count=%0d addr=%0d data=%h, required 1 0 0100",
                     wa.size(), (wa.size() > 0) ? wa[0] : 16'hx, (wd.size() > 0) ? wd[0] : 16'hx);
        end
    endtask

    task automatic test_checksum_error;
        wa.delete(); wd.delete();
        pulse_start(1'b0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        send_byte(8'h01, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b001) begin
            errors++;
            $display("FAIL csum_status: busy=%b done=%b err=%b, required 0 0 1", busy, done, err);
        end
        checks++;
        if (wa.size() != 1 || wa[0] !== 16'd32 || wd[0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL csum_write: count=%0d addr=%0d data=%h, required 1 32 ffff",
                     wa.size(), (wa.size() > 0) ? wa[0] : 16'hx, (wd.size() > 0) ? wd[0] : 16'hx);
        end
    endtask

    task automatic test_empty_and_range;
        wa.delete(); wd.delete();
        pulse_start(1'b0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b010 || wa.size() != 0) begin
            errors++;
            $display("FAIL empty_frame: busy=%b done=%b err=%b writes=%0d, required 0 1 0 0", busy, done, err, wa.size());
        end
        pulse_start(1'b0);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL range_err_state: ready=%b busy=%b, required 0 1", bus.in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b001 || wa.size() != 0) begin
            errors++;
            $display("FAIL range_status: busy=%b done=%b err=%b writes=%0d, required 0 0 1 0", busy, done, err, wa.size());
        end
    endtask

    task automatic test_timeout;
        wa.delete(); wd.delete();
        pulse_start(1'b0);
        send_byte(8'h00, 0);
        repeat (1000) @(negedge clk);
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_early: busy=%b err=%b, required 1 0", busy, err);
        end
        repeat (40) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b001) begin
            errors++;
            $display("FAIL timeout_status: busy=%b done=%b err=%b, required 0 0 1", busy, done, err);
        end
        pulse_start(1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: err=%b, required 0", err);
        end
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        send_byte(8'h51, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b010 || wa.size() != 1 || wa[0] !== 16'd32 || wd[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL timeout_recover: busy=%b done=%b err=%b writes=%0d, required 0 1 0 1 write (32,beef)",
                     busy, done, err, wa.size());
        end
    endtask

    task automatic test_reset_mid_load;
        wa.delete(); wd.delete();
        pulse_start(1'b0);
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, cpu_hold, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_load: ready=%b we=%b addr=%h data=%h busy=%b hold=%b done=%b err=%b, required all 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, cpu_hold, done, err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulse_start(1'b0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h2E, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b010 || wa.size() != 1 || wa[0] !== 16'd32 || wd[0] !== 16'h5678) begin
            errors++;
            $display("FAIL reset_reload: busy=%b done=%b err=%b writes=%0d, required 0 1 0 1 write (32,5678)",
                     busy, done, err, wa.size());
        end
    endtask

    initial begin
        bus.in_byte  = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_basic();
        test_vector_stall();
        test_checksum_error();
        test_empty_and_range();
        test_timeout();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes the instruction memory the fetch stage reads.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit words.
- Writes each word through the instruction-memory write port, starting at either the vector area (address 0) or the program area (address 2^5).
- Holds the CPU while loading so fetch restarts cleanly afterwards.

Parameters:
- ADDR_W, 20, instruction memory address width in words.
- DATA_W, 16, instruction word width. Fixed at 2 bytes per word.
- BASE_ADDR, 32, first program-area address (2^5).
- TIMEOUT, 1024, idle cycles allowed between accepted bytes before the load aborts.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Ignored while busy.
- vec_sel  in  1  sampled with start: 1 loads from address 0, 0 loads from BASE_ADDR.
- in_byte  in  8  stream data.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts in_byte this cycle.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  a load is in progress.
- cpu_hold  out  1  equals busy; keeps the fetch PC in reset.
- done  out  1  sticky: last load succeeded.
- err  out  1  sticky: last load failed.

Behaviour:
- Reset values (asynchronous, while reset=0): state IDLE; in_ready, mem_we, busy, cpu_hold, done, err all 0; mem_addr and mem_wdata 0; all counters 0.
- Frame format: CNT_HI, CNT_LO, then N words sent high byte first, then one checksum byte. N is the 16-bit count. The checksum is the XOR of all 2N payload bytes.
- A byte is accepted only in a cycle where in_valid=1 and in_ready=1.
- in_ready=1 in states CNT_HI, CNT_LO, DAT_HI, DAT_LO and CHK; 0 otherwise.
- State IDLE: on start, clear done and err, latch base (0 or BASE_ADDR), set busy, go to CNT_HI.
- State CNT_HI: on accept, store the count high byte, go to CNT_LO.
- State CNT_LO: on accept, complete N.
  - If base+N > 2^ADDR_W, go to ERR. No writes occur.
  - Else if N=0, go to CHK.
  - Else go to DAT_HI.
- State DAT_HI: on accept, store the high byte and XOR it into the checksum. Go to DAT_LO.
- State DAT_LO: on accept, XOR the byte into the checksum.
  - The next cycle drives mem_we=1, mem_addr=base+k (k = word index from 0) and mem_wdata={hi,lo}.
  - mem_we is registered, so the next byte may be accepted in that same cycle: no stall, at most one byte per cycle.
  - After the Nth word go to CHK; otherwise go to DAT_HI.
- State CHK: on accept, compare the byte with the running checksum. Equal: go to DONE. Unequal: go to ERR.
- State DONE: done=1, busy=0, return to IDLE. done stays 1 until the next start.
- State ERR: err=1, busy=0, return to IDLE. err stays 1 until the next start. Words already written are not rolled back.
- Timeout: the counter resets on every accepted byte and on start, and counts while busy and waiting for a byte. On reaching TIMEOUT, go to ERR.
- start while busy is ignored. in_valid in IDLE is not accepted (in_ready=0).
- Address never wraps: the range check in CNT_LO guarantees base+k < 2^ADDR_W.
- Reset asserted mid-load: abort immediately, no further writes, all outputs return to reset values.
- The last word's mem_we pulse occurs no later than the cycle the checksum byte is accepted. busy deasserts the cycle after the DONE or ERR state.

Test Plan:
- Basic load: start (vec_sel=0), bytes 00 02 12 34 AB CD, checksum 0x40, in_valid held high -> mem_we pulses twice: (32,0x1234) then (33,0xABCD); done=1, err=0; busy and cpu_hold high from the start cycle until the cycle after the checksum is accepted.
- Vector load with stalls: vec_sel=1, N=1, word 0x0100, checksum 0x01, 3 idle cycles between bytes -> single write (0,0x0100); done=1; nothing written at address 32.
- Checksum error: N=1, word 0xFFFF, checksum 0x01 -> write (32,0xFFFF) occurs; err=1, done=0.
- Range and empty frames: N=0 with checksum 0x00 -> done=1 and no mem_we. Base 32 with N=0xFFFF and ADDR_W=16 -> err=1 immediately after CNT_LO, no writes.
- Timeout: after CNT_HI, hold in_valid low for TIMEOUT cycles -> err=1, busy=0. A subsequent start plus a valid frame clears err and reaches done.
- Reset mid-load: assert reset after the first data byte -> all outputs 0 asynchronously. After release, a new start with a full frame loads correctly from base.
